// File: rtl/prng_lfsr.sv
// Fibonacci LFSR that shifts one bit per clock into an OUT_W-bit word delivered over valid/ready.
// Build option LFSR_PERIOD_CHECK_EN adds a shift counter and reference register that pulse period_done.
module prng_lfsr #(
    parameter int              WIDTH      = 24,
    parameter logic [WIDTH-1:0] TAPS       = 24'hE10000,
    parameter logic [WIDTH-1:0] RESET_SEED = '1,
    parameter int              OUT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_enable,
    input  logic [WIDTH-1:0] seed,
    input  logic             run,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] state,
    output logic             busy,
    output logic             lockup,
    output logic             period_done,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [OUT_W-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lockup_q, lockup_d;
    logic             do_shift;

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic             shift_zero;
    logic [WIDTH-1:0] lfsr_shift;
    logic [OUT_W-1:0] word_shift;
    logic [OUT_W-1:0] word_first;
    logic [CW-1:0]    cnt_inc;

    // A shift that would land on all-zero is replaced by RESET_SEED; the word still takes fb.
    always_comb begin
        fb         = ^(lfsr_q & TAPS);
        shifted    = {lfsr_q[WIDTH-2:0], fb};
        shift_zero = (shifted == '0);
        lfsr_shift = shift_zero ? RESET_SEED : shifted;
        word_shift = word_q << 1;
        word_shift[0] = fb;
        word_first = '0;
        word_first[0] = fb;
        cnt_inc    = cnt_q + CW'(1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= IDLE;
            lfsr_q   <= RESET_SEED;
            word_q   <= '0;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            lfsr_q   <= lfsr_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
        end
    end

    // Handshake: a word transfers on any rising edge where out_valid and out_ready are both 1;
    // out_valid never drops and out_data never changes until that transfer or a seed load.
    always_comb begin
        fsm_d    = fsm_q;
        lfsr_d   = lfsr_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        lockup_d = 1'b0;
        do_shift = 1'b0;
        if (load_enable) begin
            lfsr_d   = (seed == '0) ? RESET_SEED : seed;
            lockup_d = (seed == '0);
            word_d   = '0;
            cnt_d    = '0;
            fsm_d    = IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (run) begin
                        fsm_d = FILL;
                        cnt_d = '0;
                    end
                end
                FILL: begin
                    if (run) begin
                        do_shift = 1'b1;
                        lfsr_d   = lfsr_shift;
                        lockup_d = shift_zero;
                        word_d   = word_shift;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == CW'(OUT_W)) begin
                            fsm_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (run) begin
                            do_shift = 1'b1;
                            lfsr_d   = lfsr_shift;
                            lockup_d = shift_zero;
                            word_d   = word_first;
                            cnt_d    = CW'(1);
                            fsm_d    = (OUT_W == 1) ? HOLD : FILL;
                        end else begin
                            word_d = '0;
                            cnt_d  = '0;
                            fsm_d  = IDLE;
                        end
                    end
                end
                default: begin
                    fsm_d = IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        out_data  = word_q;
        out_valid = (fsm_q == HOLD);
        busy      = (fsm_q == FILL);
        state     = lfsr_q;
        lockup    = lockup_q;
        fsm_state = fsm_q;
    end

`ifdef LFSR_PERIOD_CHECK_EN
    logic [WIDTH-1:0] pcnt_q;
    logic [WIDTH-1:0] ref_q;
    logic             pdone_q;

    // Reference is the state a load or reset leaves behind; a shift back onto it closes a period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q  <= '0;
            ref_q   <= RESET_SEED;
            pdone_q <= 1'b0;
        end else begin
            pdone_q <= 1'b0;
            if (load_enable) begin
                pcnt_q <= '0;
                ref_q  <= lfsr_d;
            end else if (do_shift) begin
                if (lfsr_shift == ref_q) begin
                    pdone_q <= 1'b1;
                    pcnt_q  <= '0;
                end else begin
                    pcnt_q <= pcnt_q + WIDTH'(1);
                end
            end
        end
    end

    assign period_done = pdone_q;
`else
    assign period_done = 1'b0;
`endif

endmodule

// File: tb/tb_prng_lfsr.sv
// Directed bench for prng_lfsr: default 24-bit instance plus a 4-bit OUT_W=1 instance for the period option.
module tb_prng_lfsr;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [23:0] TAPS_D = 24'hE10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        load_enable;
    logic [23:0] seed;
    logic        run;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] state;
    logic        busy;
    logic        lockup;
    logic        period_done;
    logic [1:0]  fsm_state;

    logic        load4;
    logic [3:0]  seed4;
    logic        run4;
    logic [0:0]  data4;
    logic        valid4;
    logic        ready4;
    logic [3:0]  state4;
    logic        busy4;
    logic        lockup4;
    logic        pdone4;
    logic [1:0]  fsm4;

    prng_lfsr dut (
        .clk(clk), .rst(rst), .load_enable(load_enable), .seed(seed), .run(run),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .state(state),
        .busy(busy), .lockup(lockup), .period_done(period_done), .fsm_state(fsm_state)
    );

    prng_lfsr #(.WIDTH(4), .TAPS(4'b1100), .RESET_SEED(4'hF), .OUT_W(1)) dut4 (
        .clk(clk), .rst(rst), .load_enable(load4), .seed(seed4), .run(run4),
        .out_data(data4), .out_valid(valid4), .out_ready(ready4), .state(state4),
        .busy(busy4), .lockup(lockup4), .period_done(pdone4), .fsm_state(fsm4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ms;
        logic [7:0]  mw;
        logic        mfb;
        logic        exp_pd;

        rst = 1'b1; load_enable = 1'b0; seed = '0; run = 1'b0; out_ready = 1'b0;
        load4 = 1'b0; seed4 = '0; run4 = 1'b0; ready4 = 1'b0;
        tick();
        tick();
        check("rst_state", 64'(state), 64'hFFFFFF);
        check("rst_data", 64'(out_data), 64'h0);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_lockup", 64'(lockup), 64'h0);
        check("rst_pdone", 64'(period_done), 64'h0);
        check("rst_fsm", 64'(fsm_state), 64'(S_IDLE));
        check("rst_state4", 64'(state4), 64'hF);
        rst = 1'b0;
        tick();

        // First word from reset seed; IDLE->FILL edge does not shift.
        run = 1'b1;
        tick();
        check("fill_busy", 64'(busy), 64'h1);
        check("fill_noshift", 64'(state), 64'hFFFFFF);
        repeat (7) tick();
        check("w1_not_yet", 64'(out_valid), 64'h0);
        tick();
        check("w1_valid", 64'(out_valid), 64'h1);
        check("w1_data", 64'(out_data), 64'h00);
        check("w1_state", 64'(state), 64'hFFFF00);
        check("w1_busy", 64'(busy), 64'h0);

        // Backpressure: word and state frozen.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data", 64'(out_data), 64'h00);
            check("hold_state", 64'(state), 64'hFFFF00);
            check("hold_valid", 64'(out_valid), 64'h1);
        end
        out_ready = 1'b1; run = 1'b0;
        tick();
        check("hs_stop_valid", 64'(out_valid), 64'h0);
        check("hs_stop_fsm", 64'(fsm_state), 64'(S_IDLE));
        check("hs_stop_data", 64'(out_data), 64'h0);
        out_ready = 1'b0;
        repeat (3) tick();
        check("idle_state", 64'(state), 64'hFFFF00);
        check("idle_busy", 64'(busy), 64'h0);

        // Seed load, then run toggled every cycle while filling.
        load_enable = 1'b1; seed = 24'h123456;
        tick();
        load_enable = 1'b0;
        check("load_state", 64'(state), 64'h123456);
        check("load_lockup", 64'(lockup), 64'h0);
        ms = 24'h123456; mw = '0;
        run = 1'b1;
        tick();
        check("tog_start", 64'(state), 64'(ms));
        for (int k = 0; k < 16; k++) begin
            run = k[0];
            tick();
            if (k[0]) begin
                mfb = ^(ms & TAPS_D);
                ms  = {ms[22:0], mfb};
                mw  = {mw[6:0], mfb};
            end
            check("tog_state", 64'(state), 64'(ms));
        end
        check("tog_valid", 64'(out_valid), 64'h1);
        check("tog_data", 64'(out_data), 64'(mw));

        // Load in HOLD with out_ready and run high: load wins.
        load_enable = 1'b1; seed = 24'hABCDEF; out_ready = 1'b1; run = 1'b1;
        tick();
        load_enable = 1'b0; out_ready = 1'b0; run = 1'b0;
        check("ldhold_state", 64'(state), 64'hABCDEF);
        check("ldhold_valid", 64'(out_valid), 64'h0);
        check("ldhold_data", 64'(out_data), 64'h0);
        check("ldhold_fsm", 64'(fsm_state), 64'(S_IDLE));

        // Zero seed is rejected.
        load_enable = 1'b1; seed = 24'h0;
        tick();
        load_enable = 1'b0;
        check("zero_state", 64'(state), 64'hFFFFFF);
        check("zero_lockup", 64'(lockup), 64'h1);
        check("zero_valid", 64'(out_valid), 64'h0);
        check("zero_fsm", 64'(fsm_state), 64'(S_IDLE));
        tick();
        check("zero_lockup_end", 64'(lockup), 64'h0);

        // Sustained throughput: one word every 8 cycles.
        run = 1'b1; out_ready = 1'b1;
        tick();
        repeat (8) tick();
        check("tp_w1_valid", 64'(out_valid), 64'h1);
        check("tp_w1_state", 64'(state), 64'hFFFF00);
        tick();
        check("tp_gap_valid", 64'(out_valid), 64'h0);
        check("tp_gap_busy", 64'(busy), 64'h1);
        repeat (6) tick();
        check("tp_w2_not_yet", 64'(out_valid), 64'h0);
        tick();
        check("tp_w2_valid", 64'(out_valid), 64'h1);
        check("tp_w2_data", 64'(out_data), 64'h00);
        check("tp_w2_state", 64'(state), 64'hFF0000);

        // Asynchronous reset mid-word.
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_state", 64'(state), 64'hFFFFFF);
        check("arst_valid", 64'(out_valid), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_data", 64'(out_data), 64'h0);
        run = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b0;
        tick();
        check("arst_after_state", 64'(state), 64'hFFFFFF);
        check("arst_after_valid", 64'(out_valid), 64'h0);

        // Period of the 4-bit maximal LFSR from seed 1.
        load4 = 1'b1; seed4 = 4'h1;
        tick();
        load4 = 1'b0;
        check("p4_load", 64'(state4), 64'h1);
        run4 = 1'b1; ready4 = 1'b1;
        tick();
        check("p4_fill_noshift", 64'(state4), 64'h1);
        for (int i = 1; i <= 31; i++) begin
            tick();
`ifdef LFSR_PERIOD_CHECK_EN
            exp_pd = (i == 15) || (i == 30);
`else
            exp_pd = 1'b0;
`endif
            check("p4_pdone", 64'(pdone4), 64'(exp_pd));
            if (i == 15 || i == 30) begin
                check("p4_state_back", 64'(state4), 64'h1);
            end
            if (i == 3) begin
                check("p4_state3", 64'(state4), 64'h9);
            end
        end
        run4 = 1'b0; ready4 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
